// File: rtl/l2_set_buf.sv
// l2_set_buf: queue of L2 set read-out snapshots, kept coherent with single-way SRAM writes.
// Defining L2_SET_BUF_BYPASS_EN lets a push into an empty buffer reach head_* in the same cycle.
module l2_set_buf #(
    parameter int WAYS    = 8,
    parameter int LINE_W  = 128,
    parameter int TAG_W   = 20,
    parameter int HPROT_W = 1,
    parameter int STATE_W = 3,
    parameter int SET_W   = 9,
    parameter int DEPTH   = 2,
    parameter int WAY_W   = $clog2(WAYS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_valid,
    output logic                        push_ready,
    input  logic [SET_W-1:0]            push_set,
    input  logic [WAYS*LINE_W-1:0]      push_line,
    input  logic [WAYS*TAG_W-1:0]       push_tag,
    input  logic [WAYS*HPROT_W-1:0]     push_hprot,
    input  logic [WAYS*STATE_W-1:0]     push_state,
    input  logic [WAY_W-1:0]            push_evict_way,
    output logic                        head_valid,
    input  logic                        pop,
    output logic [SET_W-1:0]            head_set,
    output logic [WAYS*LINE_W-1:0]      head_line,
    output logic [WAYS*TAG_W-1:0]       head_tag,
    output logic [WAYS*HPROT_W-1:0]     head_hprot,
    output logic [WAYS*STATE_W-1:0]     head_state,
    output logic [WAY_W-1:0]            head_evict_way,
    input  logic                        upd_en,
    input  logic [SET_W-1:0]            upd_set,
    input  logic [WAY_W-1:0]            upd_way,
    input  logic [LINE_W-1:0]           upd_line,
    input  logic [TAG_W-1:0]            upd_tag,
    input  logic [HPROT_W-1:0]          upd_hprot,
    input  logic [STATE_W-1:0]          upd_state,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [SET_W-1:0]        ent_set   [DEPTH];
    logic [WAYS*LINE_W-1:0]  ent_line  [DEPTH];
    logic [WAYS*TAG_W-1:0]   ent_tag   [DEPTH];
    logic [WAYS*HPROT_W-1:0] ent_hprot [DEPTH];
    logic [WAYS*STATE_W-1:0] ent_state [DEPTH];
    logic [WAY_W-1:0]        ent_evict [DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [DEPTH-1:0]        live;
    logic                    empty, push_fire, store, deq, byp_sel;
    logic [WAYS*LINE_W-1:0]  m_line;
    logic [WAYS*TAG_W-1:0]   m_tag;
    logic [WAYS*HPROT_W-1:0] m_hprot;
    logic [WAYS*STATE_W-1:0] m_state;

    assign empty      = count == '0;
    assign push_ready = count != CW'(DEPTH);
    assign push_fire  = push_valid && push_ready;
    assign deq        = pop && !empty;
`ifdef L2_SET_BUF_BYPASS_EN
    assign head_valid = !empty || push_fire;
    assign store      = push_fire && !(empty && pop);
    assign byp_sel    = empty;
`else
    assign head_valid = !empty;
    assign store      = push_fire;
    assign byp_sel    = 1'b0;
`endif

    // Pushed snapshot with a same-cycle SRAM write to its set folded in.
    always_comb begin
        m_line  = push_line;
        m_tag   = push_tag;
        m_hprot = push_hprot;
        m_state = push_state;
        if (upd_en && upd_set == push_set) begin
            m_line[upd_way*LINE_W +: LINE_W]    = upd_line;
            m_tag[upd_way*TAG_W +: TAG_W]       = upd_tag;
            m_hprot[upd_way*HPROT_W +: HPROT_W] = upd_hprot;
            m_state[upd_way*STATE_W +: STATE_W] = upd_state;
        end
    end

    // An entry takes updates if occupied and not being popped this cycle.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++)
            live[i] = ((i >= int'(rd_ptr) ? i - int'(rd_ptr) : i + DEPTH - int'(rd_ptr)) < int'(count))
                      && !(deq && i == int'(rd_ptr));
    end

    always_comb begin
        head_set       = !head_valid ? '0 : byp_sel ? push_set       : ent_set[rd_ptr];
        head_line      = !head_valid ? '0 : byp_sel ? m_line         : ent_line[rd_ptr];
        head_tag       = !head_valid ? '0 : byp_sel ? m_tag          : ent_tag[rd_ptr];
        head_hprot     = !head_valid ? '0 : byp_sel ? m_hprot        : ent_hprot[rd_ptr];
        head_state     = !head_valid ? '0 : byp_sel ? m_state        : ent_state[rd_ptr];
        head_evict_way = !head_valid ? '0 : byp_sel ? push_evict_way : ent_evict[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_set[i]   <= '0;
                ent_line[i]  <= '0;
                ent_tag[i]   <= '0;
                ent_hprot[i] <= '0;
                ent_state[i] <= '0;
                ent_evict[i] <= '0;
            end
        end else begin
            if (store)
                wr_ptr <= wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr == PW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(store) - CW'(deq);
            for (int i = 0; i < DEPTH; i++)
                if (upd_en && live[i] && ent_set[i] == upd_set) begin
                    ent_line[i][upd_way*LINE_W +: LINE_W]    <= upd_line;
                    ent_tag[i][upd_way*TAG_W +: TAG_W]       <= upd_tag;
                    ent_hprot[i][upd_way*HPROT_W +: HPROT_W] <= upd_hprot;
                    ent_state[i][upd_way*STATE_W +: STATE_W] <= upd_state;
                end
            if (store) begin
                ent_set[wr_ptr]   <= push_set;
                ent_line[wr_ptr]  <= m_line;
                ent_tag[wr_ptr]   <= m_tag;
                ent_hprot[wr_ptr] <= m_hprot;
                ent_state[wr_ptr] <= m_state;
                ent_evict[wr_ptr] <= push_evict_way;
            end
        end
    end
endmodule

// File: tb/tb_l2_set_buf.sv
// tb_l2_set_buf: directed and random checks of l2_set_buf against a queue-based snapshot model.
module tb_l2_set_buf;
    typedef struct packed {
        logic [8:0]    set;
        logic [1023:0] line;
        logic [159:0]  tag;
        logic [7:0]    hprot;
        logic [23:0]   state;
        logic [2:0]    ev;
    } ent_t;

`ifdef L2_SET_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0, push_valid = 1'b0, pop = 1'b0, upd_en = 1'b0;
    logic push_ready, head_valid;
    ent_t pin = '0, got;
    logic [8:0]    head_set, upd_set = '0;
    logic [1023:0] head_line;
    logic [159:0]  head_tag;
    logic [7:0]    head_hprot;
    logic [23:0]   head_state;
    logic [2:0]    head_evict_way, upd_way = '0, upd_state = '0;
    logic [127:0]  upd_line = '0;
    logic [19:0]   upd_tag = '0;
    logic [0:0]    upd_hprot = '0;
    logic [1:0]    count;
    ent_t q[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    l2_set_buf dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
        .push_set(pin.set), .push_line(pin.line), .push_tag(pin.tag), .push_hprot(pin.hprot),
        .push_state(pin.state), .push_evict_way(pin.ev), .head_valid(head_valid), .pop(pop),
        .head_set(head_set), .head_line(head_line), .head_tag(head_tag), .head_hprot(head_hprot),
        .head_state(head_state), .head_evict_way(head_evict_way), .upd_en(upd_en),
        .upd_set(upd_set), .upd_way(upd_way), .upd_line(upd_line), .upd_tag(upd_tag),
        .upd_hprot(upd_hprot), .upd_state(upd_state), .count(count)
    );

    assign got = {head_set, head_line, head_tag, head_hprot, head_state, head_evict_way};

    function automatic ent_t apply_upd(input ent_t e);
        if (upd_en && e.set == upd_set) begin
            e.line[int'(upd_way)*128 +: 128] = upd_line;
            e.tag[int'(upd_way)*20 +: 20]    = upd_tag;
            e.hprot[int'(upd_way)]           = upd_hprot[0];
            e.state[int'(upd_way)*3 +: 3]    = upd_state;
        end
        return e;
    endfunction

    function automatic bit exp_hv();
        return q.size() > 0 || (BYP && push_valid);
    endfunction

    function automatic ent_t exp_head();
        if (q.size() > 0) return q[0];
        if (BYP && push_valid) return apply_upd(pin);
        return '0;
    endfunction

    // Snapshot-queue semantics applied to the inputs that were present at the edge.
    task automatic model_step();
        bit pf = push_valid && q.size() < 2;
        ent_t pe = apply_upd(pin);
        if (BYP && pf && pop && q.size() == 0) return;
        if (pop && q.size() > 0) void'(q.pop_front());
        foreach (q[i]) q[i] = apply_upd(q[i]);
        if (pf) q.push_back(pe);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle();
        push_valid = 1'b0;
        pop = 1'b0;
        upd_en = 1'b0;
    endtask

    task automatic rand_ent(input logic [8:0] s);
        for (int i = 0; i < 32; i++) pin.line[i*32 +: 32] = $urandom();
        for (int i = 0; i < 5; i++) pin.tag[i*32 +: 32] = $urandom();
        pin.hprot = 8'($urandom());
        pin.state = 24'($urandom());
        pin.ev = 3'($urandom_range(7));
        pin.set = s;
    endtask

    task automatic rand_upd(input logic [8:0] s);
        upd_set = s;
        upd_way = 3'($urandom_range(7));
        upd_line = {$urandom(), $urandom(), $urandom(), $urandom()};
        upd_tag = 20'($urandom());
        upd_hprot = 1'($urandom());
        upd_state = 3'($urandom());
    endtask

    task automatic drain();
        for (int k = 0; k < 6 && q.size() > 0; k++) begin
            pop = 1'b1;
            tick();
        end
        idle();
        #1;
        total++;
        if (count !== 2'd0 || head_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: count=%0d hv=%b, want 0/0", count, head_valid);
        end
    endtask

    task automatic test_reset();
        idle();
        #3;
        total++;
        if (head_valid !== 1'b0 || count !== 2'd0 || push_ready !== 1'b1 || got !== '0) begin
            bad++;
            $display("FAIL reset: hv=%b count=%0d ready=%b set=%h, want 0/0/1/0", head_valid, count, push_ready, head_set);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
    endtask

    task automatic test_basic();
        rand_ent(9'h05);
        pin.tag[60 +: 20] = 20'hABCDE;
        pin.ev = 3'd3;
        push_valid = 1'b1;
        #1;
        total++;
        if (head_valid !== BYP) begin
            bad++;
            $display("FAIL basic_pre: hv=%b want %b", head_valid, BYP);
        end
        tick();
        idle();
        #1;
        total++;
        if (head_valid !== 1'b1 || head_set !== 9'h05 || head_tag[60 +: 20] !== 20'hABCDE ||
            head_evict_way !== 3'd3 || count !== 2'd1) begin
            bad++;
            $display("FAIL basic: hv=%b set=%h tag3=%h ev=%0d count=%0d, want 1/05/abcde/3/1",
                     head_valid, head_set, head_tag[60 +: 20], head_evict_way, count);
        end
        total++;
        if (got !== exp_head()) begin
            bad++;
            $display("FAIL basic_entry: tag=%h want %h", head_tag, exp_head().tag);
        end
        drain();
    endtask

    task automatic test_full();
        rand_ent(9'd1);
        push_valid = 1'b1;
        tick();
        rand_ent(9'd2);
        tick();
        rand_ent(9'd3);
        #1;
        total++;
        if (push_ready !== 1'b0 || count !== 2'd2) begin
            bad++;
            $display("FAIL full: ready=%b count=%0d, want 0/2", push_ready, count);
        end
        pop = 1'b1;
        #1;
        total++;
        if (push_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_ready: ready=%b want 0", push_ready);
        end
        tick();
        pop = 1'b0;
        #1;
        total++;
        if (head_set !== 9'd2 || push_ready !== 1'b1 || count !== 2'd1) begin
            bad++;
            $display("FAIL full_after_pop: set=%0d ready=%b count=%0d, want 2/1/1", head_set, push_ready, count);
        end
        tick();
        idle();
        #1;
        total++;
        if (count !== 2'd2 || q.size() != 2 || q[1].set != 9'd3) begin
            bad++;
            $display("FAIL full_accept: count=%0d want 2", count);
        end
        drain();
    endtask

    task automatic test_update();
        rand_ent(9'd7);
        push_valid = 1'b1;
        tick();
        rand_ent(9'd9);
        tick();
        idle();
        rand_upd(9'd9);
        upd_way = 3'd2;
        upd_state = 3'b101;
        upd_en = 1'b1;
        tick();
        idle();
        #1;
        total++;
        if (head_set !== 9'd7 || got !== exp_head()) begin
            bad++;
            $display("FAIL upd_other: set=%0d state=%h, want 7 state=%h", head_set, head_state, exp_head().state);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        #1;
        total++;
        if (head_set !== 9'd9 || head_state[6 +: 3] !== 3'b101 || got !== exp_head()) begin
            bad++;
            $display("FAIL upd_match: set=%0d way2=%0d line=%h, want 9/5 line=%h",
                     head_set, head_state[6 +: 3], head_line[383:256], exp_head().line[383:256]);
        end
        drain();
    endtask

    task automatic test_push_upd();
        rand_ent(9'd4);
        push_valid = 1'b1;
        rand_upd(9'd4);
        upd_way = 3'd0;
        upd_line = '1;
        upd_en = 1'b1;
        tick();
        idle();
        #1;
        total++;
        if (head_line[127:0] !== {128{1'b1}} || got !== exp_head()) begin
            bad++;
            $display("FAIL push_upd: way0=%h want all ones", head_line[127:0]);
        end
        drain();
    endtask

    task automatic test_wrap();
        rand_ent(9'd20);
        push_valid = 1'b1;
        tick();
        for (int k = 0; k < 10; k++) begin
            rand_ent(9'(21 + k));
            push_valid = 1'b1;
            pop = 1'b1;
            tick();
            #1;
            total++;
            if (count !== 2'd1 || head_set !== 9'(21 + k) || got !== exp_head()) begin
                bad++;
                $display("FAIL wrap%0d: count=%0d set=%0d, want 1/%0d", k, count, head_set, 21 + k);
            end
        end
        pop = 1'b0;
        rand_ent(9'd40);
        tick();
        rst = 1'b0;
        q.delete();
        #1;
        total++;
        if (head_valid !== 1'b0 || count !== 2'd0 || push_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: hv=%b count=%0d ready=%b, want 0/0/1", head_valid, count, push_ready);
        end
        idle();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_bypass();
        rand_ent(9'h11);
        push_valid = 1'b1;
        pop = 1'b1;
        #1;
        total++;
        if (head_valid !== BYP || (BYP && head_set !== 9'h11)) begin
            bad++;
            $display("FAIL bypass_head: hv=%b set=%h, want %b", head_valid, head_set, BYP);
        end
        tick();
        idle();
        #1;
        total++;
        if (count !== (BYP ? 2'd0 : 2'd1)) begin
            bad++;
            $display("FAIL bypass_count: count=%0d want %0d", count, BYP ? 0 : 1);
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rand_ent(9'($urandom_range(3)));
            push_valid = $urandom_range(2) != 0;
            pop = $urandom_range(2) == 0;
            upd_en = $urandom_range(1) != 0;
            rand_upd(9'($urandom_range(3)));
            #1;
            total++;
            if (head_valid !== exp_hv() || count !== 2'(q.size()) || push_ready !== (q.size() < 2) || got !== exp_head()) begin
                bad++;
                $display("FAIL random%0d: hv=%b count=%0d ready=%b set=%h st=%h, want %b/%0d/%b set=%h st=%h",
                         k, head_valid, count, push_ready, head_set, head_state,
                         exp_hv(), q.size(), q.size() < 2, exp_head().set, exp_head().state);
            end
            tick();
        end
        idle();
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_update();
        test_push_upd();
        test_wrap();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
